ioctl_sender: RTL and testbench
===============================

# ioctl_sender

Transmitter side of the core's ioctl download bus. It takes a byte stream from a valid/ready source and a start command, then drives ioctl_download, ioctl_index, ioctl_wr, ioctl_addr and ioctl_dout exactly as the HPS loader does, honouring ioctl_wait back-pressure. It sits in the Verilator testbench top and in on-FPGA self-test builds, feeding ROM images into bocks_top without the HPS.

## Interface

Parameters:
- ADDR_W, 25, width of ioctl_addr and length
- WR_GAP, 3, idle cycles inserted after every ioctl_wr strobe (0 allowed)

Ports:
- clk_sys  in  1  system clock; all logic on rising edge
- reset_n  in  1  reset; one clock, synchronous, active-low
- start  in  1  one-cycle command strobe; ignored while busy=1
- index  in  8  download index, latched on accepted start
- length  in  ADDR_W  byte count, latched on accepted start
- s_data  in  8  source byte
- s_valid  in  1  source byte valid
- s_ready  out  1  byte accepted when s_valid & s_ready at an edge
- ioctl_download  out  1  transfer-in-progress flag
- ioctl_index  out  8  latched index
- ioctl_wr  out  1  one-cycle write strobe
- ioctl_addr  out  ADDR_W  byte offset of the current byte
- ioctl_dout  out  8  current byte
- ioctl_wait  in  1  sink back-pressure
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse

## Operation

- States: IDLE, ARM, FETCH, WRITE, GAP, TAIL.
- IDLE:
  - start=1 and length≠0 -> ARM; latch index and length; clear byte counter.
  - start=1 and length=0 -> stay in IDLE, done=1 next cycle; download never asserted.
- ARM: ioctl_download=1 for one cycle -> FETCH.
- FETCH: s_ready = ~ioctl_wait.
  - On handshake: register ioctl_dout=s_data and ioctl_addr=counter -> WRITE.
  - Otherwise stay in FETCH.
- WRITE: ioctl_wr=1 for exactly one cycle; counter+1.
  - WR_GAP>0 -> GAP.
  - WR_GAP=0 and last byte -> TAIL.
  - Otherwise -> FETCH.
- GAP: count down WR_GAP cycles, then -> TAIL if last byte, else FETCH.
- TAIL: one cycle, ioctl_download still 1 -> IDLE. On the following cycle ioctl_download=0 and done=1.
- ioctl_dout and ioctl_addr hold their values between strobes; they change only on a handshake.
- ioctl_index holds its value after completion until the next accepted start.
- Counter is ADDR_W bits. Last byte means counter == length-1 at WRITE. No wrap occurs because length < 2^ADDR_W.
- s_ready=0 in every state except FETCH.
- ioctl_wait:
  - Only blocks acceptance of the next byte.
  - A strobe already in WRITE always completes, even if ioctl_wait rises in that cycle.
  - GAP countdown continues while ioctl_wait is high.
- busy=1 in ARM, FETCH, WRITE, GAP and TAIL.
- start received while busy is dropped and has no effect.
- Reset (reset_n=0 sampled at an edge): next cycle state=IDLE and every output is 0, i.e. ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, s_ready, busy and done. A transfer in progress is abandoned without a done pulse.

## Timing

- Cycle numbering: start sampled at edge 0; "cycle n" is the register state after edge n.
- Cycle 1: ARM, ioctl_download=1, busy=1. Cycle 2: FETCH, s_ready=1.
- With no stalls, the first ioctl_wr is at cycle 3. Strobes then repeat every 2+WR_GAP cycles.
- ioctl_wr for byte k (0-based) at cycle 3 + k·(2+WR_GAP) when unstalled.
- After the last strobe at cycle L: ioctl_download falls and done pulses at cycle L+WR_GAP+2.
- Source stall or ioctl_wait adds exactly one cycle per stalled FETCH cycle.
- Acceptance latency is one cycle: a byte handshaken at edge n appears with ioctl_wr=1 at cycle n+1.

## Test plan

- WR_GAP=2, index=8'h01, length=4, bytes A0..A3 always valid -> ioctl_wr at cycles 3,7,11,15 with addr 0..3 and dout A0..A3; download high cycles 1–18; done=1 and download=0 at cycle 19.
- WR_GAP=0, length=3, s_valid low for cycles 2–4 before the first byte -> first ioctl_wr at cycle 6, then at cycles 8 and 10; done at cycle 12.
- WR_GAP=3, length=2, ioctl_wait=1 during cycles 7–10 -> second byte accepted at edge 11 (s_ready=0 during cycles 7–10), ioctl_wr at cycles 3 and 12, dout/addr held stable in between.
- length=0 with start -> done=1 at cycle 1; ioctl_download, ioctl_wr and busy never asserted.
- start pulsed again at cycle 5 of a length=4 transfer -> ignored; exactly 4 strobes; index stays latched.
- reset_n=0 at edge 8 mid-transfer -> cycle 8 shows all outputs 0 with no done pulse; a new start at edge 10 restarts at addr 0 with ioctl_wr at cycle 13.

Source files
------------

// File: rtl/ioctl_sender_if.sv
`default_nettype none
// ============================================================================
//  Module      : ioctl_sender_if
//  Description : ioctl download bus as seen between a loader (master) and
//                the core consuming the image (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface ioctl_sender_if #(
    parameter int ADDR_W = 25
);
    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic              ioctl_wait;

    // Loader side: drives the bus, receives back-pressure
    modport master (
        output ioctl_download,
        output ioctl_index,
        output ioctl_wr,
        output ioctl_addr,
        output ioctl_dout,
        input  ioctl_wait
    );

    // Core side: consumes the bus, may stall the loader
    modport slave (
        input  ioctl_download,
        input  ioctl_index,
        input  ioctl_wr,
        input  ioctl_addr,
        input  ioctl_dout,
        output ioctl_wait
    );
endinterface
`default_nettype wire

// File: rtl/ioctl_sender.sv
`default_nettype none
// ============================================================================
//  Module      : ioctl_sender
//  Description : Replays a valid/ready byte stream onto the ioctl download
//                bus with the same strobe pattern as the HPS loader:
//                download raised one cycle ahead, one ioctl_wr per byte,
//                WR_GAP idle cycles after each strobe, one tail cycle,
//                then a one-cycle done pulse. ioctl_wait only delays the
//                fetch of the next byte.
//  Revision    : 1.0  initial release
// ============================================================================
module ioctl_sender #(
    parameter int ADDR_W = 25,
    parameter int WR_GAP = 3
) (
    input  wire logic              clk_sys,
    input  wire logic              reset_n,
    input  wire logic              start,
    input  wire logic [7:0]        index,
    input  wire logic [ADDR_W-1:0] length,
    input  wire logic [7:0]        s_data,
    input  wire logic              s_valid,
    output logic                   s_ready,
    ioctl_sender_if.master         bus,
    output logic                   busy,
    output logic                   done
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_TAIL  = 3'd5;

    // Gap counter holds WR_GAP-1 down to 0; at least one bit so the
    // register stays legal when WR_GAP is 0 (GAP is then never entered).
    localparam int GAP_W      = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;
    localparam int GAP_LOAD_I = (WR_GAP > 0) ? (WR_GAP - 1) : 0;
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_LOAD_I[GAP_W-1:0];
    localparam logic [GAP_W-1:0]  GAP_ONE  = {{(GAP_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------
    logic [2:0]        r_state;
    logic [2:0]        w_next;

    logic [7:0]        r_index;
    logic [ADDR_W-1:0] r_length;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_dout;
    logic [GAP_W-1:0]  r_gap;
    logic              r_done;

    logic              w_start_idle;
    logic              w_zero_len;
    logic              w_accept;
    logic              w_last_wr;
    logic              w_last_gap;

    // A start only counts in IDLE; a zero length completes without a transfer
    assign w_start_idle = (r_state == S_IDLE) && start;
    assign w_zero_len   = (length == '0);

    // Byte handshake: only in FETCH and only while the sink is not stalling
    assign w_accept = (r_state == S_FETCH) && s_valid && !bus.ioctl_wait;

    // In WRITE the counter still points at the byte being strobed;
    // after WRITE it has advanced, so the last-byte test shifts by one.
    assign w_last_wr  = (r_count == (r_length - ADDR_ONE));
    assign w_last_gap = (r_count == r_length);

    // State register with synchronous active-low reset
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && !w_zero_len) begin
                    w_next = S_ARM;
                end
            end
            S_ARM: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                if (w_accept) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (WR_GAP > 0) begin
                    w_next = S_GAP;
                end else if (w_last_wr) begin
                    w_next = S_TAIL;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_GAP: begin
                if (r_gap == '0) begin
                    w_next = w_last_gap ? S_TAIL : S_FETCH;
                end
            end
            S_TAIL: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State-decoded outputs: strobe, download window, busy and source ready
    always_comb begin
        s_ready            = 1'b0;
        busy               = 1'b0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        case (r_state)
            S_ARM: begin
                busy               = 1'b1;
                bus.ioctl_download = 1'b1;
            end
            S_FETCH: begin
                busy               = 1'b1;
                bus.ioctl_download = 1'b1;
                s_ready            = !bus.ioctl_wait;
            end
            S_WRITE: begin
                busy               = 1'b1;
                bus.ioctl_download = 1'b1;
                bus.ioctl_wr       = 1'b1;
            end
            S_GAP: begin
                busy               = 1'b1;
                bus.ioctl_download = 1'b1;
            end
            S_TAIL: begin
                busy               = 1'b1;
                bus.ioctl_download = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Datapath: latched command, byte counter, bus data/address, gap timer, done
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_index  <= '0;
            r_length <= '0;
            r_count  <= '0;
            r_addr   <= '0;
            r_dout   <= '0;
            r_gap    <= '0;
            r_done   <= 1'b0;
        end else begin
            // Done fires for an empty request or on leaving TAIL
            r_done <= (w_start_idle && w_zero_len) || (r_state == S_TAIL);

            if (w_start_idle) begin
                r_index <= index;
                if (!w_zero_len) begin
                    r_length <= length;
                    r_count  <= '0;
                end
            end

            // Address and data only move on a handshake, so they hold
            // steady across the strobe, the gap and any stall.
            if (w_accept) begin
                r_addr <= r_count;
                r_dout <= s_data;
            end

            if (r_state == S_WRITE) begin
                r_count <= r_count + ADDR_ONE;
                r_gap   <= GAP_LOAD;
            end else if ((r_state == S_GAP) && (r_gap != '0)) begin
                r_gap <= r_gap - GAP_ONE;
            end
        end
    end

    assign bus.ioctl_index = r_index;
    assign bus.ioctl_addr  = r_addr;
    assign bus.ioctl_dout  = r_dout;
    assign done            = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ioctl_sender.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ioctl_sender
//  Description : Three senders (WR_GAP 0, 2, 3) share one random stimulus
//                stream; each is compared every cycle against an
//                event-timing reference model derived from the transfer
//                rules (strobe at handshake+1, next fetch after the gap,
//                done two cycles after the gap of the last byte).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ioctl_sender;

    localparam int ADDR_W = 25;
    localparam int NDUT   = 3;
    localparam int NCYC   = 6000;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic              reset_n    = 1'b0;
    logic              start      = 1'b0;
    logic [7:0]        index      = '0;
    logic [ADDR_W-1:0] length     = '0;
    logic [7:0]        s_data     = '0;
    logic              s_valid    = 1'b0;
    logic              ioctl_wait = 1'b0;

    logic [NDUT-1:0]   rdy_o;
    logic [NDUT-1:0]   busy_o;
    logic [NDUT-1:0]   done_o;
    logic [NDUT-1:0]   dl_o;
    logic [NDUT-1:0]   wr_o;
    logic [ADDR_W-1:0] addr_o [NDUT];
    logic [7:0]        dout_o [NDUT];
    logic [7:0]        idx_o  [NDUT];

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        localparam int GAP = (gi == 0) ? 0 : ((gi == 1) ? 2 : 3);
        logic s_ready_w;
        logic busy_w;
        logic done_w;

        ioctl_sender_if #(.ADDR_W(ADDR_W)) bus ();
        assign bus.ioctl_wait = ioctl_wait;

        ioctl_sender #(.ADDR_W(ADDR_W), .WR_GAP(GAP)) dut (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .start   (start),
            .index   (index),
            .length  (length),
            .s_data  (s_data),
            .s_valid (s_valid),
            .s_ready (s_ready_w),
            .bus     (bus),
            .busy    (busy_w),
            .done    (done_w)
        );

        assign rdy_o[gi]  = s_ready_w;
        assign busy_o[gi] = busy_w;
        assign done_o[gi] = done_w;
        assign dl_o[gi]   = bus.ioctl_download;
        assign wr_o[gi]   = bus.ioctl_wr;
        assign addr_o[gi] = bus.ioctl_addr;
        assign dout_o[gi] = bus.ioctl_dout;
        assign idx_o[gi]  = bus.ioctl_index;
    end

    // ------------------------------------------------------------------
    // Reference model: per sender, the transfer is tracked as a few
    // event times (next cycle a byte may be fetched, cycle of the next
    // strobe, cycle of the done pulse) rather than as a state machine.
    // ------------------------------------------------------------------
    int                gap_tab [NDUT] = '{0, 2, 3};
    bit                m_active [NDUT];
    int                m_len    [NDUT];
    int                m_sent   [NDUT];
    int                m_fetch  [NDUT];
    int                m_wr_cyc [NDUT];
    int                m_done_cyc [NDUT];
    logic [7:0]        m_idx    [NDUT];
    logic [7:0]        m_dout   [NDUT];
    logic [ADDR_W-1:0] m_addr   [NDUT];

    int errors = 0;
    int checks = 0;
    int strobes = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance model of sender g from cycle n to n+1 using the cycle-n inputs
    task automatic model_step(input int g, input int n);
        bit was_active;
        bit hs;
        if (!reset_n) begin
            m_active[g]   = 1'b0;
            m_len[g]      = 0;
            m_sent[g]     = 0;
            m_fetch[g]    = 0;
            m_wr_cyc[g]   = -1;
            m_done_cyc[g] = -1;
            m_idx[g]      = '0;
            m_dout[g]     = '0;
            m_addr[g]     = '0;
        end else begin
            was_active = m_active[g];
            hs = was_active && (m_sent[g] < m_len[g]) && (n >= m_fetch[g])
                 && !ioctl_wait && s_valid;
            if (hs) begin
                m_addr[g]   = ADDR_W'(m_sent[g]);
                m_dout[g]   = s_data;
                m_wr_cyc[g] = n + 1;
                m_sent[g]++;
                m_fetch[g]  = n + 2 + gap_tab[g];
                if (m_sent[g] == m_len[g]) begin
                    m_done_cyc[g] = n + 3 + gap_tab[g];
                end
            end
            if (was_active && (m_done_cyc[g] == n + 1)) begin
                m_active[g] = 1'b0;
            end
            if (!was_active && start) begin
                m_idx[g] = index;
                if (length == '0) begin
                    m_done_cyc[g] = n + 1;
                end else begin
                    m_active[g]   = 1'b1;
                    m_len[g]      = int'(length);
                    m_sent[g]     = 0;
                    m_fetch[g]    = n + 2;
                    m_done_cyc[g] = -1;
                end
            end
        end
    endtask

    initial begin
        bit model_ok;
        bit exp_rdy;
        model_ok = 1'b0;
        for (int n = 0; n < NCYC; n++) begin
            @(negedge clk_sys);
            // Inputs for cycle n
            reset_n    = (n < 2) ? 1'b0 : ($urandom_range(0, 399) != 0);
            start      = ($urandom_range(0, 5) == 0);
            index      = 8'($urandom);
            length     = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom_range(1, 6));
            s_valid    = ($urandom_range(0, 9) < 7);
            s_data     = 8'($urandom);
            ioctl_wait = ($urandom_range(0, 4) == 0);
            #1;
            if (model_ok) begin
                for (int g = 0; g < NDUT; g++) begin
                    exp_rdy = m_active[g] && (m_sent[g] < m_len[g]) && (n >= m_fetch[g]) && !ioctl_wait;
                    check_val($sformatf("ready[g%0d] c%0d", g, n), 32'(rdy_o[g]), 32'(exp_rdy));
                    check_val($sformatf("busy[g%0d] c%0d", g, n), 32'(busy_o[g]), 32'(m_active[g]));
                    check_val($sformatf("download[g%0d] c%0d", g, n), 32'(dl_o[g]), 32'(m_active[g]));
                    check_val($sformatf("wr[g%0d] c%0d", g, n), 32'(wr_o[g]), 32'(m_wr_cyc[g] == n));
                    check_val($sformatf("done[g%0d] c%0d", g, n), 32'(done_o[g]), 32'(m_done_cyc[g] == n));
                    check_val($sformatf("addr[g%0d] c%0d", g, n), 32'(addr_o[g]), 32'(m_addr[g]));
                    check_val($sformatf("dout[g%0d] c%0d", g, n), 32'(dout_o[g]), 32'(m_dout[g]));
                    check_val($sformatf("index[g%0d] c%0d", g, n), 32'(idx_o[g]), 32'(m_idx[g]));
                    if (m_wr_cyc[g] == n) strobes++;
                end
            end
            for (int g = 0; g < NDUT; g++) begin
                model_step(g, n);
            end
            if (!reset_n) model_ok = 1'b1;
        end
        // The random run must actually have exercised byte transfers
        check_val("strobes_seen_nonzero", 32'(strobes > 100), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
